// File: rtl/xbee_tx_arbiter.sv
// Two-requester byte arbiter in front of the XBee UART transmitter.
// Round-robin between handshake logic (0) and PicoBlaze (1), with busy handshake, timeout and inter-byte gap.
module xbee_tx_arbiter #(
  parameter int GAP_CYCLES   = 16,
  parameter int BUSY_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        conn_established,
  input  logic [7:0]  req0_data,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req1_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  output logic [7:0]  tx_data,
  output logic        tx_send,
  input  logic        tx_busy,
  output logic        grant_id,
  output logic        arb_busy,
  output logic        timeout_err,
  input  logic        clr_err,
  output logic [15:0] byte_count
);

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_e;

  // The timer starts at 0 in SEND, so the WAIT_BUSY cycle holding BUSY_TIMEOUT-1
  // is the last chance for tx_busy; the flag then shows BUSY_TIMEOUT cycles after tx_send.
  localparam logic [31:0] BusyLast = 32'(BUSY_TIMEOUT - 1);
  localparam logic [31:0] GapLast  = 32'(GAP_CYCLES - 1);
  localparam state_e      AfterTx  = (GAP_CYCLES == 0) ? IDLE : GAP;

  state_e      state_q, state_d;
  logic [7:0]  txData_q, txData_d;
  logic        grantId_q, grantId_d;
  logic        lastGrant_q, lastGrant_d;
  logic        timeoutErr_q, timeoutErr_d;
  logic [15:0] byteCount_q, byteCount_d;
  logic [31:0] timer_q, timer_d;
  logic        take0, take1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      txData_q     <= 8'h00;
      grantId_q    <= 1'b0;
      lastGrant_q  <= 1'b1;
      timeoutErr_q <= 1'b0;
      byteCount_q  <= 16'h0000;
      timer_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      txData_q     <= txData_d;
      grantId_q    <= grantId_d;
      lastGrant_q  <= lastGrant_d;
      timeoutErr_q <= timeoutErr_d;
      byteCount_q  <= byteCount_d;
      timer_q      <= timer_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    txData_d     = txData_q;
    grantId_d    = grantId_q;
    lastGrant_d  = lastGrant_q;
    timeoutErr_d = timeoutErr_q;
    byteCount_d  = byteCount_q;
    timer_d      = timer_q;
    take0        = 1'b0;
    take1        = 1'b0;

    if (clr_err) begin
      timeoutErr_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (req0_valid && req1_valid && conn_established) begin
          take0 = lastGrant_q;
          take1 = ~lastGrant_q;
        end else if (req0_valid) begin
          take0 = 1'b1;
        end else if (req1_valid && conn_established) begin
          take1 = 1'b1;
        end
        if (take0 || take1) begin
          grantId_d   = take1;
          lastGrant_d = take1;
          txData_d    = take1 ? req1_data : req0_data;
          timer_d     = 32'd0;
          state_d     = SEND;
        end
      end
      SEND: begin
        byteCount_d = byteCount_q + 16'd1;
        timer_d     = timer_q + 32'd1;
        state_d     = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (timer_q >= BusyLast) begin
          timeoutErr_d = 1'b1;
          timer_d      = 32'd0;
          state_d      = AfterTx;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          timer_d = 32'd0;
          state_d = AfterTx;
        end
      end
      GAP: begin
        if (timer_q >= GapLast) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Strobes are masked during reset so nothing leaks out of an aborted transfer.
  assign req0_ready  = take0 & ~reset;
  assign req1_ready  = take1 & ~reset;
  assign tx_send     = (state_q == SEND) & ~reset;
  assign arb_busy    = (state_q != IDLE) & ~reset;
  assign tx_data     = txData_q;
  assign grant_id    = grantId_q;
  assign timeout_err = timeoutErr_q;
  assign byte_count  = byteCount_q;

endmodule

// File: tb/tb_xbee_tx_arbiter.sv
// Randomized bench for xbee_tx_arbiter against a transaction-timing reference model.
// The model predicts grants from queue contents and the end of each transfer from the chosen busy profile.
module tb_xbee_tx_arbiter;

  localparam int GAP = 4;
  localparam int BT  = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        conn_established;
  logic [7:0]  req0_data, req1_data;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [7:0]  tx_data;
  logic        tx_send;
  logic        tx_busy;
  logic        grant_id;
  logic        arb_busy;
  logic        timeout_err;
  logic        clr_err;
  logic [15:0] byte_count;

  xbee_tx_arbiter #(.GAP_CYCLES(GAP), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .reset(reset), .conn_established(conn_established),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(req1_ready),
    .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
    .grant_id(grant_id), .arb_busy(arb_busy), .timeout_err(timeout_err),
    .clr_err(clr_err), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  int checkCount = 0;
  int errorCount = 0;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit rstDrive = 1'b1, connDrive = 1'b0, clrDrive = 1'b0, autoFill = 1'b0;
  int busyMode = 0;

  // Reference model: a transfer is described by its send cycle and the busy profile
  // handed to the fake transmitter; the first free cycle follows by arithmetic.
  bit         inXfer = 1'b0;
  int         sendCyc = 0, busyRise = 0, busyLen = 0, idleAt = 0;
  bit         expGrant = 1'b0, lastGrant = 1'b1, expErr = 1'b0;
  logic [7:0] expData = 8'h00;
  logic [15:0] expCount = 16'h0000;

  int         sendGrant[$];
  int         sendAt[$];
  logic [7:0] sendData[$];
  int         ready1Seen = 0;
  int         errRiseAt = -1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cycle, observed, expected);
    end
  endtask

  task automatic clearLogs();
    sendGrant.delete();
    sendAt.delete();
    sendData.delete();
    ready1Seen = 0;
    errRiseAt  = -1;
  endtask

  task automatic chooseBusy();
    case (busyMode)
      1: begin busyRise = 1; busyLen = 10; end
      2: begin busyRise = -1; busyLen = 0; end
      3: begin
        if ($urandom_range(5) == 0) begin
          busyRise = -1; busyLen = 0;
        end else begin
          busyRise = int'($urandom_range(BT - 1, 1));
          busyLen  = int'($urandom_range(12, 1));
        end
      end
      default: begin
        busyRise = int'($urandom_range(BT - 1, 1));
        busyLen  = int'($urandom_range(12, 1));
      end
    endcase
  endtask

  task automatic applyStimulus();
    bit busyNow, elig0, elig1, pick, doGrant;
    @(negedge clk);
    reset            = rstDrive;
    conn_established = connDrive;
    clr_err          = clrDrive;
    req0_valid       = (q0.size() > 0);
    req1_valid       = (q1.size() > 0);
    req0_data        = req0_valid ? q0[0] : 8'h00;
    req1_data        = req1_valid ? q1[0] : 8'h00;
    busyNow = inXfer && (busyRise >= 0) && (cycle >= sendCyc + busyRise) &&
              (cycle < sendCyc + busyRise + busyLen);
    tx_busy = busyNow && !rstDrive;
    #1;

    elig0   = (q0.size() > 0);
    elig1   = (q1.size() > 0) && connDrive;
    doGrant = !rstDrive && !inXfer && (cycle >= idleAt) && (elig0 || elig1);
    pick    = (elig0 && elig1) ? !lastGrant : elig1;

    checkOutput("req0_ready", req0_ready, doGrant && !pick);
    checkOutput("req1_ready", req1_ready, doGrant && pick);
    checkOutput("tx_send", tx_send, !rstDrive && inXfer && (cycle == sendCyc));
    if (!rstDrive) begin
      checkOutput("arb_busy", arb_busy, inXfer);
      checkOutput("grant_id", grant_id, expGrant);
      checkOutput("tx_data", tx_data, expData);
      checkOutput("byte_count", byte_count, expCount);
      checkOutput("timeout_err", timeout_err, expErr);
      if (tx_send) begin
        sendGrant.push_back(int'(grant_id));
        sendAt.push_back(cycle);
        sendData.push_back(tx_data);
      end
      if (req1_ready) ready1Seen++;
      if (timeout_err && errRiseAt < 0) errRiseAt = cycle;
    end

    if (rstDrive) begin
      inXfer = 1'b0; idleAt = cycle + 1; expGrant = 1'b0; lastGrant = 1'b1;
      expErr = 1'b0; expData = 8'h00; expCount = 16'h0000;
    end else begin
      if (inXfer && cycle == sendCyc) expCount = expCount + 16'd1;
      if (inXfer && busyRise < 0 && cycle + 1 == sendCyc + BT) expErr = 1'b1;
      else if (clrDrive) expErr = 1'b0;
      if (doGrant) begin
        expGrant  = pick;
        lastGrant = pick;
        expData   = pick ? q1.pop_front() : q0.pop_front();
        sendCyc   = cycle + 1;
        inXfer    = 1'b1;
        chooseBusy();
        idleAt = (busyRise >= 0) ? sendCyc + busyRise + busyLen + 1 + GAP : sendCyc + BT + GAP;
      end else if (inXfer && cycle + 1 >= idleAt) begin
        inXfer = 1'b0;
      end
    end

    if (autoFill) begin
      if (q0.size() == 0 && $urandom_range(3) == 0) q0.push_back(8'($urandom));
      if (q1.size() == 0 && $urandom_range(3) == 0) q1.push_back(8'($urandom));
    end
    cycle++;
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic doReset();
    q0.delete();
    q1.delete();
    rstDrive = 1'b1;
    runCycles(2);
    rstDrive = 1'b0;
  endtask

  initial begin
    int guard;
    reset = 1'b1; conn_established = 1'b0; clr_err = 1'b0; tx_busy = 1'b0;
    req0_data = 8'h00; req1_data = 8'h00; req0_valid = 1'b0; req1_valid = 1'b0;

    doReset();
    runCycles(3);

    // Link down: only requester 0 is served, requester 1 waits for the link.
    busyMode = 0; connDrive = 1'b0;
    q0.push_back(8'h41); q1.push_back(8'h55);
    clearLogs();
    runCycles(40);
    checkOutput("c37_sends", sendData.size(), 1);
    if (sendData.size() >= 1) checkOutput("c37_data", sendData[0], 8'h41);
    checkOutput("c37_req1_ready", ready1Seen, 0);
    connDrive = 1'b1;
    clearLogs();
    runCycles(40);
    checkOutput("c37_late_req1", ready1Seen, 1);

    // Both requesters contending: strict alternation starting with requester 0.
    doReset();
    connDrive = 1'b1; busyMode = 1;
    q0.push_back(8'h10); q0.push_back(8'h12);
    q1.push_back(8'h21); q1.push_back(8'h23);
    clearLogs();
    guard = 0;
    while (sendAt.size() < 4 && guard < 200) begin applyStimulus(); guard++; end
    runCycles(3);
    checkOutput("c38_nsends", sendAt.size(), 4);
    if (sendAt.size() >= 4) begin
      for (int i = 0; i < 4; i++) checkOutput("c38_grant", sendGrant[i], i % 2);
      for (int i = 1; i < 4; i++) checkOutput("c38_spacing", (sendAt[i] - sendAt[i-1]) >= 10 + GAP, 1);
    end
    checkOutput("c38_count", byte_count, 4);

    // Transmitter never answers: sticky error after BT cycles, then clear.
    doReset();
    busyMode = 2;
    q0.push_back(8'h11);
    clearLogs();
    runCycles(30);
    checkOutput("c39_sends", sendAt.size(), 1);
    if (sendAt.size() >= 1) checkOutput("c39_err_delay", errRiseAt - sendAt[0], BT);
    checkOutput("c39_idle", arb_busy, 0);
    clrDrive = 1'b1;
    applyStimulus();
    clrDrive = 1'b0;
    applyStimulus();
    checkOutput("c39_cleared", timeout_err, 0);

    // Reset while waiting for the transmitter to finish a requester-0 byte.
    doReset();
    connDrive = 1'b1; busyMode = 1;
    for (int i = 0; i < 3; i++) begin q0.push_back(8'(8'h60 + i)); q1.push_back(8'(8'h70 + i)); end
    guard = 0;
    while (!(inXfer && expGrant == 1'b0 && busyRise >= 0 && cycle > sendCyc + busyRise &&
             cycle <= sendCyc + busyRise + busyLen) && guard < 200) begin
      applyStimulus(); guard++;
    end
    checkOutput("c40_reached_wait_done", guard < 200, 1);
    rstDrive = 1'b1;
    applyStimulus();
    rstDrive = 1'b0;
    clearLogs();
    guard = 0;
    while (sendAt.size() < 1 && guard < 30) begin applyStimulus(); guard++; end
    checkOutput("c40_nsends", sendAt.size(), 1);
    if (sendGrant.size() >= 1) checkOutput("c40_grant", sendGrant[0], 0);

    // Link drops while a requester-1 byte is in flight.
    doReset();
    connDrive = 1'b1; busyMode = 0;
    q1.push_back(8'hA1); q1.push_back(8'hA2);
    guard = 0;
    while (!(inXfer && expGrant == 1'b1 && cycle == sendCyc + 1) && guard < 50) begin
      applyStimulus(); guard++;
    end
    checkOutput("c41_reached_wait_busy", guard < 50, 1);
    connDrive = 1'b0;
    clearLogs();
    runCycles(60);
    checkOutput("c41_held", ready1Seen, 0);
    checkOutput("c41_completed", byte_count, 1);
    connDrive = 1'b1;
    runCycles(40);
    checkOutput("c41_resumed", sendData.size(), 1);
    if (sendData.size() >= 1) checkOutput("c41_data", sendData[0], 8'hA2);

    // Counter wrap, using a preset instead of 65535 real sends.
    runCycles(5);
    expCount = 16'hFFFF;
    force dut.byteCount_q = 16'hFFFF;
    applyStimulus();
    release dut.byteCount_q;
    q0.push_back(8'h5A);
    runCycles(10);
    checkOutput("c42_wrap", byte_count, 0);

    // Free-running random traffic with link flaps, error clears and resets.
    doReset();
    autoFill = 1'b1; busyMode = 3;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(29) == 0) connDrive = !connDrive;
      clrDrive = ($urandom_range(39) == 0);
      rstDrive = ($urandom_range(399) == 0);
      applyStimulus();
    end
    rstDrive = 1'b0; clrDrive = 1'b0;
    runCycles(5);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
